seq_compare_unit: RTL and testbench
===================================

Name: seq_compare_unit

Overview:
- Parametrised, multi-cycle magnitude/sign comparator; successor to the 32-bit combinational zero/sign classifier.
- Compares operand A against operand B (or against zero) in signed or unsigned mode, scanning CHUNK bits per cycle from the MSB with early termination.
- Produces lt/eq/gt flags, a branch-condition result and a set-on-less-than word.
- Sits beside the ALU; used by the control unit for slt/sltu and beq/bne/blez/bgtz/bltz/bgez resolution.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle; WIDTH % CHUNK == 0 required; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only in IDLE.
- flush  input  1  synchronous abort; returns to IDLE, no done.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for zero-conditions.
- is_signed  input  1  1 = two's-complement compare.
- cond  input  3  0 EQ, 1 NE, 2 LT, 3 GE, 4 LTZ, 5 GEZ, 6 LEZ, 7 GTZ.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse; result valid.
- lt, eq, gt  output  1 each  registered compare result (A vs B, or A vs 0).
- cond_true  output  1  cond evaluated on result.
- slt_out  output  WIDTH  {WIDTH-1 zeros, lt}.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, lt, eq, gt, cond_true, slt_out all 0.
- Clocking: all state and outputs are registered; no combinational input-to-output path.
- FSM: IDLE -> SCAN -> DONE -> IDLE.
- IDLE, start=1 at an edge:
  - capture opA=a and opB=(cond>=4 ? 0 : b);
  - capture cond, and set signed = is_signed | (cond>=4), since zero-conditions are always signed;
  - if signed, invert the MSB of both captured operands, so the scan is a plain unsigned compare;
  - idx = NCHUNK-1; go to SCAN.
- SCAN, one edge per chunk, comparing opA[idx] vs opB[idx] unsigned:
  - chunks differ: set lt or gt, eq=0; go to DONE;
  - chunks equal and idx==0: eq=1, lt=gt=0; go to DONE;
  - otherwise idx=idx-1.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Result hold: lt/eq/gt/cond_true/slt_out are updated on entry to DONE and held until the next DONE or reset.
- Latency: if the first differing chunk is the k-th scanned (k=1..NCHUNK, or k=NCHUNK when equal), done goes high in the cycle after k SCAN edges. Start-to-done = k+1 edges. Max NCHUNK+1 = 5 for default parameters.
- cond_true:
  - EQ: eq; NE: ~eq;
  - LT, LTZ: lt; GE, GEZ: ~lt;
  - LEZ: lt|eq; GTZ: gt.
- Start handling: start is ignored while busy (SCAN or DONE). Back-to-back throughput is therefore one op per k+2 cycles. Captured operands are unaffected by input changes after capture.
- Flush: in SCAN or DONE, go to IDLE at the next edge with done=0; held outputs keep their previous values. Flush in IDLE has no effect. Flush and start together in IDLE: flush wins, start is dropped.
- Reset mid-SCAN: immediate return to IDLE, all outputs cleared; no done afterwards.
- Boundaries:
  - most-negative vs most-positive signed compares correctly via the MSB flip;
  - CHUNK==WIDTH gives single-cycle SCAN, k=1;
  - idx never underflows.

Test Plan:
- WIDTH=32, CHUNK=8; a=b=0x12345678, unsigned, cond=EQ; start at edge 0 -> 4 SCAN edges, done in cycle 5; eq=1, cond_true=1, slt_out=0.
- a=0x80000000, b=0x00000001, cond=LT: unsigned -> gt=1, cond_true=0, done after 1 SCAN edge; signed -> lt=1, cond_true=1, slt_out=0x00000001.
- Zero-conditions, b=0xFFFFFFFF (ignored):
  - a=0, cond=LEZ -> eq=1, cond_true=1;
  - a=0xFFFFFFFF, cond=GTZ -> lt=1, cond_true=0;
  - a=5, cond=GEZ -> gt=1, cond_true=1.
- start re-asserted every cycle during an equal compare -> exactly one done pulse per accepted op; the second op is accepted only in the cycle after done.
- rst_n low for 1 cycle during the 2nd SCAN edge, or flush there -> no done pulse. Reset clears lt/eq/gt/slt_out to 0; flush preserves the prior result.
- WIDTH=16, CHUNK=4, signed; a=0x7FF0, b=0x7FF1 -> 4 SCAN edges, lt=1, done 5 edges after start.

Source files
------------

// File: rtl/seq_compare_unit.sv
// Multi-cycle magnitude/sign comparator: scans CHUNK bits per cycle from the MSB,
// stops at the first differing chunk, then reports lt/eq/gt, a branch condition and slt.
module seq_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic [2:0]       cond,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             cond_true,
  output logic [WIDTH-1:0] slt_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_next;
  logic [WIDTH-1:0] op_a, op_b, op_a_shift, op_b_shift;
  logic [IDXW-1:0]  idx;
  logic [2:0]       cond_q;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             chunk_lt, chunk_gt, chunk_eq, finish, accept, cond_eval, sgn;
  logic [WIDTH-1:0] flip;

  assign chunk_a  = op_a[WIDTH-1 -: CHUNK];
  assign chunk_b  = op_b[WIDTH-1 -: CHUNK];
  assign chunk_lt = chunk_a < chunk_b;
  assign chunk_gt = chunk_a > chunk_b;
  assign chunk_eq = ~(chunk_lt | chunk_gt);
  assign finish   = ~chunk_eq | (idx == '0);
  assign accept   = (state == IDLE) && start && !flush;

  // Zero-conditions are always signed; flipping the MSB turns a signed compare into unsigned
  assign sgn  = is_signed | cond[2];
  assign flip = sgn ? MSB : '0;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  generate
    if (NCHUNK > 1) begin : g_shift
      assign op_a_shift = op_a << CHUNK;
      assign op_b_shift = op_b << CHUNK;
    end else begin : g_noshift
      assign op_a_shift = op_a;
      assign op_b_shift = op_b;
    end
  endgenerate

  always_comb begin
    cond_eval = 1'b0;
    case (cond_q)
      3'd0:       cond_eval = chunk_eq;
      3'd1:       cond_eval = ~chunk_eq;
      3'd2, 3'd4: cond_eval = chunk_lt;
      3'd3, 3'd5: cond_eval = ~chunk_lt;
      3'd6:       cond_eval = chunk_lt | chunk_eq;
      3'd7:       cond_eval = chunk_gt;
      default:    cond_eval = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SCAN;
      SCAN: begin
        if (flush)       state_next = IDLE;
        else if (finish) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are only written on the final scan step, so flush leaves them untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      idx       <= '0;
      cond_q    <= '0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      cond_true <= 1'b0;
      slt_out   <= '0;
    end else if (accept) begin
      op_a   <= a ^ flip;
      op_b   <= (cond[2] ? '0 : b) ^ flip;
      cond_q <= cond;
      idx    <= IDX_TOP;
    end else if (state == SCAN && !flush) begin
      if (finish) begin
        lt        <= chunk_lt;
        eq        <= chunk_eq;
        gt        <= chunk_gt;
        cond_true <= cond_eval;
        slt_out   <= WIDTH'(chunk_lt);
      end else begin
        op_a <= op_a_shift;
        op_b <= op_b_shift;
        idx  <= idx - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_compare_unit.sv
// Directed bench for seq_compare_unit: default 32/8 instance plus a 16/4 instance.
module tb_seq_compare_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush, is_signed;
  logic [31:0] a, b;
  logic [2:0]  cond;
  logic        busy, done, lt, eq, gt, cond_true;
  logic [31:0] slt_out;

  logic        start2, busy2, done2, lt2, eq2, gt2, ct2;
  logic [15:0] a2, b2, slt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_compare_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .a(a), .b(b),
    .is_signed(is_signed), .cond(cond), .busy(busy), .done(done), .lt(lt),
    .eq(eq), .gt(gt), .cond_true(cond_true), .slt_out(slt_out)
  );

  seq_compare_unit #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start2), .flush(1'b0), .a(a2), .b(b2),
    .is_signed(1'b1), .cond(3'd2), .busy(busy2), .done(done2), .lt(lt2),
    .eq(eq2), .gt(gt2), .cond_true(ct2), .slt_out(slt2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request through the accepting edge, then scrambles the operand inputs
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                               input logic sg, input logic [2:0] cd);
    a = va; b = vb; is_signed = sg; cond = cd; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va; b = ~vb; cond = ~cd;
  endtask

  task automatic runOp(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic sg, input logic [2:0] cd,
                       input logic elt, input logic eeq, input logic egt,
                       input logic ect, input int ek);
    int k;
    applyStimulus(va, vb, sg, cd);
    k = 0;
    while (!done && k < 12) begin
      tick();
      k++;
    end
    checkOutput({tag, ".lat"}, k, ek);
    checkOutput({tag, ".lt"}, lt, elt);
    checkOutput({tag, ".eq"}, eq, eeq);
    checkOutput({tag, ".gt"}, gt, egt);
    checkOutput({tag, ".ct"}, cond_true, ect);
    checkOutput({tag, ".slt"}, slt_out, {31'd0, elt});
    tick();
    checkOutput({tag, ".pulse"}, done, 1'b0);
    checkOutput({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    int ndone, first, second, k;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
    a = '0; b = '0; cond = '0; start2 = 1'b0; a2 = '0; b2 = '0;
    #12;
    checkOutput("rst.busy", busy, 1'b0);
    checkOutput("rst.done", done, 1'b0);
    checkOutput("rst.res", {lt, eq, gt, cond_true}, 4'b0000);
    checkOutput("rst.slt", slt_out, 32'd0);
    rst_n = 1'b1;
    tick();

    //           tag     a             b             sg    cond  lt eq gt ct  k
    runOp("eq",   32'h12345678, 32'h12345678, 1'b0, 3'd0, 0, 1, 0, 1, 4);
    runOp("ltu",  32'h80000000, 32'h00000001, 1'b0, 3'd2, 0, 0, 1, 0, 1);
    runOp("lts",  32'h80000000, 32'h00000001, 1'b1, 3'd2, 1, 0, 0, 1, 1);
    runOp("lez",  32'h00000000, 32'hFFFFFFFF, 1'b0, 3'd6, 0, 1, 0, 1, 4);
    runOp("gtz",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3'd7, 1, 0, 0, 0, 1);
    runOp("ne",   32'h12005678, 32'h12345678, 1'b0, 3'd1, 1, 0, 0, 1, 2);
    runOp("geu",  32'h12345600, 32'h12345678, 1'b0, 3'd3, 1, 0, 0, 0, 4);
    runOp("ltz",  32'h80000000, 32'h00000000, 1'b0, 3'd4, 1, 0, 0, 1, 1);
    runOp("gez",  32'h00000005, 32'hFFFFFFFF, 1'b0, 3'd5, 0, 0, 1, 1, 4);

    // Flush on the 2nd scan edge: no done, prior "gez" result kept
    applyStimulus(32'd1, 32'd2, 1'b0, 3'd2);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      tick();
    end
    checkOutput("flush.done", ndone, 0);
    checkOutput("flush.hold", {lt, eq, gt, cond_true}, 4'b0011);
    checkOutput("flush.busy", busy, 1'b0);

    // Start held high continuously: ops accepted at edges 0 and 6, done after 4 and 10
    a = 32'hCAFEF00D; b = 32'hCAFEF00D; is_signed = 1'b0; cond = 3'd0; start = 1'b1;
    tick();
    ndone = 0; first = -1; second = -1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (done) begin
        ndone++;
        if (first < 0) first = i; else second = i;
      end
    end
    start = 1'b0;
    checkOutput("b2b.count", ndone, 2);
    checkOutput("b2b.first", first, 4);
    checkOutput("b2b.second", second, 10);
    checkOutput("b2b.eq", eq, 1'b1);

    // Reset during the 2nd scan edge after an slt=1 result
    runOp("pre", 32'h80000000, 32'h00000001, 1'b1, 3'd2, 1, 0, 0, 1, 1);
    applyStimulus(32'h0000FFFF, 32'h0000FFFF, 1'b0, 3'd0);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("arst.res", {lt, eq, gt, cond_true}, 4'b0000);
    checkOutput("arst.slt", slt_out, 32'd0);
    checkOutput("arst.busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      tick();
    end
    checkOutput("arst.done", ndone, 0);

    // 16-bit / 4-bit chunk instance, signed LT
    a2 = 16'h7FF0; b2 = 16'h7FF1; start2 = 1'b1;
    tick();
    start2 = 1'b0; a2 = 16'h0000; b2 = 16'hFFFF;
    k = 0;
    while (!done2 && k < 12) begin
      tick();
      k++;
    end
    checkOutput("w16.lat", k, 4);
    checkOutput("w16.res", {lt2, eq2, gt2, ct2}, 4'b1001);
    checkOutput("w16.slt", slt2, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
